id_ex_operand_stage: RTL and testbench
======================================

# id_ex_operand_stage

Decode-to-execute operand stage of the 64-bit LEGv8 pipeline: holds the 32×64 register file, reads source operands for the instruction in ID, and registers them with control into the ID/EX pipeline register that feeds the ALU's `dataA`, `dataB` and `ALUctrl` inputs. It resolves data hazards by forwarding from MEM and WB on its outputs, and detects load-use hazards to stall decode and insert a bubble. Branch resolution flushes it.

## Interface
- `XZR_IDX`, default 31: register index that reads as zero and ignores writes.
- `clk` input 1: single clock; all state updates on rising edge.
- `rst_n` input 1: synchronous, active-low reset.
- `id_valid` input 1: ID holds a real instruction.
- `id_rn`, `id_rm`, `id_rd` input 5 each: source A, source B, destination.
- `id_reg2loc` input 1: second read port uses `id_rd` instead of `id_rm` (STUR/CBZ).
- `id_alusrc` input 1: B operand is `id_imm`.
- `id_imm` input 64: sign-extended immediate.
- `id_aluctrl` input 4: ALU operation code, passed through.
- `id_regwrite`, `id_memread`, `id_memwrite` input 1 each: control.
- `mem_regwrite` input 1, `mem_rd` input 5, `mem_result` input 64: MEM-stage forwarding source.
- `wb_regwrite` input 1, `wb_rd` input 5, `wb_data` input 64: WB write port and forwarding source.
- `ex_flush` input 1: squash the instruction entering EX.
- `id_stall` output 1: hold IF/ID and PC this cycle.
- `ex_valid` output 1: EX holds a real instruction.
- `ex_dataA`, `ex_dataB`, `ex_store_data` output 64: ALU operands and store data.
- `ex_aluctrl` output 4, `ex_rd` output 5, `ex_regwrite`, `ex_memread`, `ex_memwrite` output 1 each.

## Operation
- Register file: 32×64. Write on the clock edge when `wb_regwrite` and `wb_rd != XZR_IDX`. Reads are combinational; index `XZR_IDX` returns 0. Write-first bypass: reading the same register that WB writes this cycle returns `wb_data`.
- B read index: `rb = id_reg2loc ? id_rd : id_rm`.
- Pipeline register captures `rn`, `rb`, the two read values, `id_imm`, `id_alusrc`, `id_aluctrl`, `id_rd` and control, with `valid = id_valid`.
- Load-use hazard (`id_stall` = 1, combinational) when `ex_valid && ex_memread && ex_rd != XZR_IDX && id_valid` and either `id_rn == ex_rd`, or `rb == ex_rd` with `(!id_alusrc || id_reg2loc || id_memwrite)`.
- Update priority each edge:
  - `!rst_n` loads all zeros.
  - Otherwise `ex_flush` or `id_stall` loads a bubble: valid, regwrite, memread, memwrite = 0.
  - Otherwise capture ID.
  - Flush dominates stall. `id_stall` is still reported during a flush.
- Forwarding (combinational on outputs, only when `ex_valid`), per source (A uses captured `rn`, B uses captured `rb`), in priority order:
  - MEM if `mem_regwrite && mem_rd != XZR_IDX && mem_rd == src`.
  - Otherwise WB under the same rule using the `wb_*` signals.
  - Otherwise the captured value.
  - Captured index `XZR_IDX` never forwards and yields 0.
- `ex_store_data` = forwarded B. `ex_dataB = alusrc ? imm : forwarded B`. `ex_dataA` = forwarded A.
- When `!ex_valid`, all 64-bit outputs are 0.

## Timing
- Latency: 1 cycle from ID inputs to EX outputs. Forwarding adds no cycles.
- Reset values, outputs during and after `rst_n` low: all EX outputs 0, `ex_valid` 0, all registers 0. `id_stall` is 0 because `ex_valid` is 0.
- Reset mid-operation clears the in-flight EX instruction. No partial state survives.
- A stall lasts exactly one cycle per load-use pair. In the next cycle EX holds the bubble, so the hazard clears and the load result forwards from MEM.
- Simultaneous WB write and ID read of the same register: the new value is captured via the register-file bypass.
- Simultaneous MEM and WB matches: MEM wins.

## Test plan
- Reset: hold `rst_n`=0 for 2 cycles with random inputs → all outputs 0. Write X5 = 0x1234 via WB, then read X5 → `ex_dataA` = 0x1234 one cycle after ID.
- XZR: WB writes X31 = 0xFFFF. ID with rn=31, rm=31 → `ex_dataA` = `ex_dataB` = 0, even with `mem_rd`=31 and `mem_regwrite`=1.
- Forward priority: EX rn=3, `mem_rd`=3 with result 0xAA, `wb_rd`=3 with data 0xBB → `ex_dataA` = 0xAA. Drop `mem_regwrite` → 0xBB.
- Load-use: EX holds LDUR rd=4. ID presents ADD rn=4 → `id_stall`=1 for one cycle and the next `ex_valid`=0. ADD enters EX the following cycle and forwards `mem_result`.
- Flush vs stall: assert `ex_flush` during a load-use stall → next `ex_valid`=0, `ex_regwrite`=0, `ex_memwrite`=0.
- Immediate/store: STUR with rn=1, rd=2, imm=8, X1=0x100, X2=0x55 → `ex_dataA`=0x100, `ex_dataB`=8, `ex_store_data`=0x55.

Source files
------------

// File: rtl/id_ex_operand_stage.sv
// id_ex_operand_stage
// Decode-to-execute operand stage of the 64-bit LEGv8 pipeline.
// Holds the 32x64 register file, reads the ID operands and registers them
// into the ID/EX pipeline register. It forwards results from MEM and WB onto
// the EX outputs. It also detects load-use hazards, which stall decode and
// insert a bubble.
//
// Ports:
//   clk, rst_n                    clock, synchronous active-low reset
//   id_valid, id_rn/rm/rd         ID instruction and its register indices
//   id_reg2loc, id_alusrc, id_imm B-read select, immediate select, immediate
//   id_aluctrl, id_regwrite/memread/memwrite  control passed to EX
//   mem_regwrite/rd/result        MEM forwarding source
//   wb_regwrite/rd/data           WB write port and forwarding source
//   ex_flush                      squash the instruction entering EX
//   id_stall                      load-use stall request to IF/ID and PC
//   ex_*                          EX-stage operands and control
module id_ex_operand_stage #(
  parameter int unsigned XZR_IDX = 31
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        id_valid,
  input  logic [4:0]  id_rn,
  input  logic [4:0]  id_rm,
  input  logic [4:0]  id_rd,
  input  logic        id_reg2loc,
  input  logic        id_alusrc,
  input  logic [63:0] id_imm,
  input  logic [3:0]  id_aluctrl,
  input  logic        id_regwrite,
  input  logic        id_memread,
  input  logic        id_memwrite,
  input  logic        mem_regwrite,
  input  logic [4:0]  mem_rd,
  input  logic [63:0] mem_result,
  input  logic        wb_regwrite,
  input  logic [4:0]  wb_rd,
  input  logic [63:0] wb_data,
  input  logic        ex_flush,
  output logic        id_stall,
  output logic        ex_valid,
  output logic [63:0] ex_dataA,
  output logic [63:0] ex_dataB,
  output logic [63:0] ex_store_data,
  output logic [3:0]  ex_aluctrl,
  output logic [4:0]  ex_rd,
  output logic        ex_regwrite,
  output logic        ex_memread,
  output logic        ex_memwrite
);

  localparam logic [4:0] XZR = XZR_IDX[4:0];

  logic [63:0] regs [32];

  // ID/EX pipeline register
  logic [4:0]  rn_q, rb_q, rd_q;
  logic [63:0] a_q, b_q, imm_q;
  logic        alusrc_q;
  logic [3:0]  aluctrl_q;
  logic        valid_q, regwrite_q, memread_q, memwrite_q;

  logic [4:0]  rb;
  logic [63:0] rd_a, rd_b, fwd_a, fwd_b;
  logic        wb_writes;

  assign rb        = id_reg2loc ? id_rd : id_rm;
  assign wb_writes = wb_regwrite && (wb_rd != XZR);

  // Combinational read with write-first bypass from the WB port.
  function automatic logic [63:0] rf_read(input logic [4:0] idx,
                                          input logic        wr,
                                          input logic [4:0]  wr_idx,
                                          input logic [63:0] wr_data,
                                          input logic [63:0] stored);
    if (idx == XZR)                 return '0;
    else if (wr && wr_idx == idx)   return wr_data;
    else                            return stored;
  endfunction

  // MEM beats WB; XZR never forwards and always reads as zero.
  function automatic logic [63:0] forward(input logic [4:0]  src,
                                          input logic [63:0] captured,
                                          input logic        m_rw,
                                          input logic [4:0]  m_rd,
                                          input logic [63:0] m_val,
                                          input logic        w_rw,
                                          input logic [4:0]  w_rd,
                                          input logic [63:0] w_val);
    if (src == XZR)                                return '0;
    else if (m_rw && m_rd != XZR && m_rd == src)   return m_val;
    else if (w_rw && w_rd != XZR && w_rd == src)   return w_val;
    else                                           return captured;
  endfunction

  always_comb begin
    rd_a = rf_read(id_rn, wb_writes, wb_rd, wb_data, regs[id_rn]);
    rd_b = rf_read(rb,    wb_writes, wb_rd, wb_data, regs[rb]);
  end

  // B only matters as a register source when it is not replaced by the
  // immediate, or when it is the store data / CBZ operand (reg2loc, memwrite).
  always_comb begin
    id_stall = 1'b0;
    if (valid_q && memread_q && rd_q != XZR && id_valid) begin
      if (id_rn == rd_q)
        id_stall = 1'b1;
      else if (rb == rd_q && (!id_alusrc || id_reg2loc || id_memwrite))
        id_stall = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < 32; i++) regs[i] <= '0;
    end else if (wb_writes) begin
      regs[wb_rd] <= wb_data;
    end
  end

  // Datapath fields are captured even for a bubble; only the control bits
  // are cleared, and the 64-bit outputs are gated off by valid anyway.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rn_q       <= '0;
      rb_q       <= '0;
      rd_q       <= '0;
      a_q        <= '0;
      b_q        <= '0;
      imm_q      <= '0;
      alusrc_q   <= 1'b0;
      aluctrl_q  <= '0;
      valid_q    <= 1'b0;
      regwrite_q <= 1'b0;
      memread_q  <= 1'b0;
      memwrite_q <= 1'b0;
    end else begin
      rn_q      <= id_rn;
      rb_q      <= rb;
      rd_q      <= id_rd;
      a_q       <= rd_a;
      b_q       <= rd_b;
      imm_q     <= id_imm;
      alusrc_q  <= id_alusrc;
      aluctrl_q <= id_aluctrl;
      if (ex_flush || id_stall) begin
        valid_q    <= 1'b0;
        regwrite_q <= 1'b0;
        memread_q  <= 1'b0;
        memwrite_q <= 1'b0;
      end else begin
        valid_q    <= id_valid;
        regwrite_q <= id_regwrite;
        memread_q  <= id_memread;
        memwrite_q <= id_memwrite;
      end
    end
  end

  always_comb begin
    fwd_a = forward(rn_q, a_q, mem_regwrite, mem_rd, mem_result,
                    wb_regwrite, wb_rd, wb_data);
    fwd_b = forward(rb_q, b_q, mem_regwrite, mem_rd, mem_result,
                    wb_regwrite, wb_rd, wb_data);
  end

  assign ex_valid      = valid_q;
  assign ex_dataA      = valid_q ? fwd_a : '0;
  assign ex_dataB      = valid_q ? (alusrc_q ? imm_q : fwd_b) : '0;
  assign ex_store_data = valid_q ? fwd_b : '0;
  assign ex_aluctrl    = aluctrl_q;
  assign ex_rd         = rd_q;
  assign ex_regwrite   = regwrite_q;
  assign ex_memread    = memread_q;
  assign ex_memwrite   = memwrite_q;

endmodule

// File: tb/tb_id_ex_operand_stage.sv
module tb_id_ex_operand_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        id_valid;
  logic [4:0]  id_rn, id_rm, id_rd;
  logic        id_reg2loc, id_alusrc;
  logic [63:0] id_imm;
  logic [3:0]  id_aluctrl;
  logic        id_regwrite, id_memread, id_memwrite;
  logic        mem_regwrite;
  logic [4:0]  mem_rd;
  logic [63:0] mem_result;
  logic        wb_regwrite;
  logic [4:0]  wb_rd;
  logic [63:0] wb_data;
  logic        ex_flush;
  logic        id_stall, ex_valid;
  logic [63:0] ex_dataA, ex_dataB, ex_store_data;
  logic [3:0]  ex_aluctrl;
  logic [4:0]  ex_rd;
  logic        ex_regwrite, ex_memread, ex_memwrite;

  int n_tests = 0;
  int n_fail  = 0;

  id_ex_operand_stage #(.XZR_IDX(31)) dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid),
    .id_rn(id_rn), .id_rm(id_rm), .id_rd(id_rd),
    .id_reg2loc(id_reg2loc), .id_alusrc(id_alusrc), .id_imm(id_imm),
    .id_aluctrl(id_aluctrl), .id_regwrite(id_regwrite),
    .id_memread(id_memread), .id_memwrite(id_memwrite),
    .mem_regwrite(mem_regwrite), .mem_rd(mem_rd), .mem_result(mem_result),
    .wb_regwrite(wb_regwrite), .wb_rd(wb_rd), .wb_data(wb_data),
    .ex_flush(ex_flush), .id_stall(id_stall), .ex_valid(ex_valid),
    .ex_dataA(ex_dataA), .ex_dataB(ex_dataB), .ex_store_data(ex_store_data),
    .ex_aluctrl(ex_aluctrl), .ex_rd(ex_rd), .ex_regwrite(ex_regwrite),
    .ex_memread(ex_memread), .ex_memwrite(ex_memwrite)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  rn, rm, rd;
    logic        reg2loc, alusrc;
    logic [63:0] imm;
    logic [3:0]  aluctrl;
    logic        mrw;
    logic [4:0]  mrd;
    logic [63:0] mres;
    logic        wrw;
    logic [4:0]  wrd;
    logic [63:0] wdat;
    logic [63:0] ea, eb, es;
  } vec_t;

  vec_t vecs [8];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic idle();
    id_valid = 0; id_rn = 0; id_rm = 0; id_rd = 0; id_reg2loc = 0;
    id_alusrc = 0; id_imm = 0; id_aluctrl = 0; id_regwrite = 0;
    id_memread = 0; id_memwrite = 0; mem_regwrite = 0; mem_rd = 0;
    mem_result = 0; wb_regwrite = 0; wb_rd = 0; wb_data = 0; ex_flush = 0;
  endtask

  task automatic wb_write(input logic [4:0] idx, input logic [63:0] data);
    wb_regwrite = 1; wb_rd = idx; wb_data = data;
    @(posedge clk); #1;
    wb_regwrite = 0;
  endtask

  // Puts LDUR X4,[X1] into EX and leaves ID idle.
  task automatic load_into_ex();
    idle();
    id_valid = 1; id_rn = 1; id_rd = 4; id_alusrc = 1; id_imm = 0;
    id_regwrite = 1; id_memread = 1; id_aluctrl = 4'h2;
    @(posedge clk); #1;
    idle();
  endtask

  initial begin
    vecs[0] = '{5'd1, 5'd2, 5'd9, 1'b0, 1'b0, 64'h0, 4'h2, 1'b0, 5'd0, 64'h0, 1'b0, 5'd0, 64'h0,
                64'h100, 64'h55, 64'h55};
    vecs[1] = '{5'd3, 5'd2, 5'd9, 1'b0, 1'b1, 64'h8, 4'h6, 1'b0, 5'd0, 64'h0, 1'b0, 5'd0, 64'h0,
                64'h300, 64'h8, 64'h55};
    vecs[2] = '{5'd3, 5'd4, 5'd10, 1'b0, 1'b0, 64'h0, 4'h0, 1'b1, 5'd3, 64'hAA, 1'b1, 5'd3, 64'hBB,
                64'hAA, 64'h400, 64'h400};
    vecs[3] = '{5'd3, 5'd4, 5'd10, 1'b0, 1'b0, 64'h0, 4'h1, 1'b0, 5'd3, 64'hAA, 1'b1, 5'd3, 64'hBB,
                64'hBB, 64'h400, 64'h400};
    vecs[4] = '{5'd31, 5'd31, 5'd11, 1'b0, 1'b0, 64'h0, 4'h2, 1'b1, 5'd31, 64'hDEAD, 1'b1, 5'd31, 64'hBEEF,
                64'h0, 64'h0, 64'h0};
    vecs[5] = '{5'd1, 5'd7, 5'd2, 1'b1, 1'b1, 64'h8, 4'h2, 1'b0, 5'd0, 64'h0, 1'b0, 5'd0, 64'h0,
                64'h100, 64'h8, 64'h55};
    vecs[6] = '{5'd5, 5'd9, 5'd4, 1'b1, 1'b0, 64'h0, 4'h7, 1'b1, 5'd4, 64'h77, 1'b0, 5'd0, 64'h0,
                64'h1234, 64'h77, 64'h77};
    vecs[7] = '{5'd1, 5'd2, 5'd12, 1'b0, 1'b0, 64'h0, 4'hC, 1'b1, 5'd2, 64'hCC, 1'b1, 5'd1, 64'hDD,
                64'hDD, 64'hCC, 64'hCC};

    // Reset with random inputs
    idle();
    rst_n = 0;
    for (int i = 0; i < 2; i++) begin
      id_valid = 1'($urandom); id_rn = 5'($urandom); id_rm = 5'($urandom);
      id_rd = 5'($urandom); id_memread = 1'($urandom); id_regwrite = 1'($urandom);
      mem_regwrite = 1'($urandom); mem_rd = 5'($urandom); mem_result = {$urandom, $urandom};
      wb_regwrite = 1'($urandom); wb_rd = 5'($urandom); wb_data = {$urandom, $urandom};
      @(posedge clk); #1;
      check("rst_valid", 64'(ex_valid), 64'h0);
      check("rst_dataA", ex_dataA, 64'h0);
      check("rst_dataB", ex_dataB, 64'h0);
      check("rst_store", ex_store_data, 64'h0);
      check("rst_stall", 64'(id_stall), 64'h0);
      check("rst_ctrl", {61'h0, ex_regwrite, ex_memread, ex_memwrite}, 64'h0);
    end
    idle();
    rst_n = 1;

    // Preload registers; X31 write must be ignored
    wb_write(5'd1, 64'h100);
    wb_write(5'd2, 64'h55);
    wb_write(5'd3, 64'h300);
    wb_write(5'd4, 64'h400);
    wb_write(5'd5, 64'h1234);
    wb_write(5'd31, 64'hFFFF);

    // Plain read of X5, one cycle latency
    id_valid = 1; id_rn = 5; id_rm = 31;
    @(posedge clk); #1;
    idle();
    #1;
    check("x5_read", ex_dataA, 64'h1234);
    check("x5_valid", 64'(ex_valid), 64'h1);

    // Table-driven vectors
    for (int i = 0; i < 8; i++) begin
      idle();
      id_valid = 1; id_regwrite = 1;
      id_rn = vecs[i].rn; id_rm = vecs[i].rm; id_rd = vecs[i].rd;
      id_reg2loc = vecs[i].reg2loc; id_alusrc = vecs[i].alusrc;
      id_imm = vecs[i].imm; id_aluctrl = vecs[i].aluctrl;
      @(posedge clk); #1;
      mem_regwrite = vecs[i].mrw; mem_rd = vecs[i].mrd; mem_result = vecs[i].mres;
      wb_regwrite = vecs[i].wrw; wb_rd = vecs[i].wrd; wb_data = vecs[i].wdat;
      id_valid = 0;
      #1;
      check($sformatf("v%0d_dataA", i), ex_dataA, vecs[i].ea);
      check($sformatf("v%0d_dataB", i), ex_dataB, vecs[i].eb);
      check($sformatf("v%0d_store", i), ex_store_data, vecs[i].es);
      check($sformatf("v%0d_aluctrl", i), 64'(ex_aluctrl), 64'(vecs[i].aluctrl));
      check($sformatf("v%0d_rd", i), 64'(ex_rd), 64'(vecs[i].rd));
    end

    // Write-first bypass: ID reads X6 while WB writes it
    idle();
    id_valid = 1; id_rn = 6; id_rm = 31;
    wb_regwrite = 1; wb_rd = 6; wb_data = 64'h66;
    @(posedge clk); #1;
    idle();
    #1;
    check("bypass_dataA", ex_dataA, 64'h66);

    // Load-use: LDUR X4 in EX, ADD X8,X4,X2 in ID
    load_into_ex();
    id_valid = 1; id_rn = 4; id_rm = 2; id_rd = 8; id_regwrite = 1;
    #1;
    check("lu_stall", 64'(id_stall), 64'h1);
    @(posedge clk); #1;
    check("lu_bubble_valid", 64'(ex_valid), 64'h0);
    check("lu_stall_clear", 64'(id_stall), 64'h0);
    check("lu_bubble_regwrite", 64'(ex_regwrite), 64'h0);
    @(posedge clk); #1;
    idle();
    mem_regwrite = 1; mem_rd = 4; mem_result = 64'h999;
    #1;
    check("lu_add_valid", 64'(ex_valid), 64'h1);
    check("lu_fwd_dataA", ex_dataA, 64'h999);
    check("lu_dataB", ex_dataB, 64'h55);

    // Immediate operand from a loaded register must not stall
    load_into_ex();
    id_valid = 1; id_rn = 1; id_rm = 4; id_alusrc = 1; id_imm = 64'h10;
    #1;
    check("lu_imm_nostall", 64'(id_stall), 64'h0);

    // Flush during a load-use stall (STUR X2,[X4])
    load_into_ex();
    id_valid = 1; id_rn = 4; id_rd = 2; id_reg2loc = 1; id_alusrc = 1;
    id_imm = 64'h8; id_memwrite = 1; ex_flush = 1;
    #1;
    check("fl_stall_reported", 64'(id_stall), 64'h1);
    @(posedge clk); #1;
    check("fl_valid", 64'(ex_valid), 64'h0);
    check("fl_regwrite", 64'(ex_regwrite), 64'h0);
    check("fl_memwrite", 64'(ex_memwrite), 64'h0);
    check("fl_dataA", ex_dataA, 64'h0);

    // Flush alone squashes a hazard-free instruction
    idle();
    id_valid = 1; id_rn = 1; id_regwrite = 1; ex_flush = 1;
    @(posedge clk); #1;
    check("flush_only_valid", 64'(ex_valid), 64'h0);

    // STUR X2,[X1,#8] without hazard
    idle();
    id_valid = 1; id_rn = 1; id_rd = 2; id_reg2loc = 1; id_alusrc = 1;
    id_imm = 64'h8; id_memwrite = 1;
    @(posedge clk); #1;
    idle();
    #1;
    check("stur_dataA", ex_dataA, 64'h100);
    check("stur_dataB", ex_dataB, 64'h8);
    check("stur_store", ex_store_data, 64'h55);
    check("stur_memwrite", 64'(ex_memwrite), 64'h1);

    // Reset mid-operation clears EX and the register file
    id_valid = 1; id_rn = 1; id_regwrite = 1;
    @(posedge clk); #1;
    check("mid_valid_before", 64'(ex_valid), 64'h1);
    rst_n = 0;
    @(posedge clk); #1;
    check("mid_rst_valid", 64'(ex_valid), 64'h0);
    check("mid_rst_dataA", ex_dataA, 64'h0);
    rst_n = 1;
    idle();
    id_valid = 1; id_rn = 1; id_rm = 2;
    @(posedge clk); #1;
    idle();
    #1;
    check("mid_rst_x1", ex_dataA, 64'h0);
    check("mid_rst_x2", ex_dataB, 64'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
